// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for alu_ctrl_seq: ALU op codes, ALUOp/funct7 encodings, sequencer states.
package alu_ctrl_pkg;

    localparam logic [3:0] OpNone = 4'd0;
    localparam logic [3:0] OpAnd  = 4'd1;
    localparam logic [3:0] OpXor  = 4'd2;
    localparam logic [3:0] OpSll  = 4'd3;
    localparam logic [3:0] OpAdd  = 4'd4;
    localparam logic [3:0] OpSub  = 4'd5;
    localparam logic [3:0] OpMul  = 4'd6;
    localparam logic [3:0] OpSrai = 4'd7;
    localparam logic [3:0] OpOr   = 4'd8;
    localparam logic [3:0] OpSrl  = 4'd9;
    localparam logic [3:0] OpSlt  = 4'd10;
    localparam logic [3:0] OpMulh = 4'd11;
    localparam logic [3:0] OpDiv  = 4'd12;
    localparam logic [3:0] OpDivu = 4'd13;
    localparam logic [3:0] OpRem  = 4'd14;
    localparam logic [3:0] OpRemu = 4'd15;

    localparam logic [1:0] AluOpIType  = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpRType  = 2'b10;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mext = 7'b0000001;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic is_mdu_op(input logic [3:0] op);
        return op inside {OpMul, OpMulh, OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative M-extension datapath: shift-add multiplier, restoring divider, sign fix-up.
// The divider is only built when ALU_CTRL_DIV_EN is defined.
module mdu_iter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            busy_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            last_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned     CntW    = $clog2(XLEN) + 1;
    localparam logic [CntW-1:0] MulLast = CntW'(XLEN / MUL_STEP - 1);
    localparam logic [CntW-1:0] DivLast = CntW'(XLEN - 1);

    logic [3:0]        r_op;
    logic              r_neg;
    logic [CntW-1:0]   r_cnt;
    logic [XLEN-1:0]   r_opb;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_result;

    logic                     w_signed, w_neg_a, w_neg_b, w_is_mul;
    logic [XLEN-1:0]          w_abs_a, w_abs_b, w_mul_final, w_final;
    logic [XLEN+MUL_STEP-1:0] w_pp, w_hi;
    logic [2*XLEN-1:0]        w_prod_nxt, w_prod_fix;

    // Operands are converted to magnitudes; the sign is reapplied to the last-step value.
    always_comb begin
        w_signed    = op_i inside {OpMul, OpMulh, OpDiv, OpRem};
        w_neg_a     = w_signed & a_i[XLEN-1];
        w_neg_b     = w_signed & b_i[XLEN-1];
        w_abs_a     = w_neg_a ? -a_i : a_i;
        w_abs_b     = w_neg_b ? -b_i : b_i;
        w_is_mul    = (r_op == OpMul) || (r_op == OpMulh);

        w_pp        = {{MUL_STEP{1'b0}}, r_opb} * {{XLEN{1'b0}}, r_prod[MUL_STEP-1:0]};
        w_hi        = {{MUL_STEP{1'b0}}, r_prod[2*XLEN-1:XLEN]} + w_pp;
        w_prod_nxt  = {w_hi, r_prod[XLEN-1:MUL_STEP]};
        w_prod_fix  = r_neg ? -w_prod_nxt : w_prod_nxt;
        w_mul_final = (r_op == OpMulh) ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];

        last_o      = busy_i && (r_cnt == (w_is_mul ? MulLast : DivLast));
    end

`ifdef ALU_CTRL_DIV_EN
    logic            r_neg_rem, r_div0;
    logic [XLEN-1:0] r_a_raw, r_quo, r_rem;
    logic [XLEN:0]   w_shift, w_diff;
    logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_div_final;
    logic            w_qbit;

    always_comb begin
        w_shift   = {r_rem, r_quo[XLEN-1]};
        w_diff    = w_shift - {1'b0, r_opb};
        w_qbit    = ~w_diff[XLEN];
        w_rem_nxt = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};
        if (r_op == OpDiv || r_op == OpDivu) begin
            w_div_final = r_div0 ? '1 : (r_neg ? -w_quo_nxt : w_quo_nxt);
        end else begin
            w_div_final = r_div0 ? r_a_raw : (r_neg_rem ? -w_rem_nxt : w_rem_nxt);
        end
        w_final = w_is_mul ? w_mul_final : w_div_final;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_a_raw   <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
        end else if (start_i) begin
            r_neg_rem <= w_neg_a;
            r_div0    <= (b_i == '0);
            r_a_raw   <= a_i;
            r_quo     <= w_abs_a;
            r_rem     <= '0;
        end else if (busy_i) begin
            r_quo     <= w_quo_nxt;
            r_rem     <= w_rem_nxt;
        end
    end
`else
    always_comb begin
        w_final = w_mul_final;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op     <= OpNone;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_opb    <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else if (start_i) begin
            r_op     <= op_i;
            r_neg    <= w_neg_a ^ w_neg_b;
            r_cnt    <= '0;
            r_opb    <= w_abs_b;
            r_prod   <= {{XLEN{1'b0}}, w_abs_a};
        end else if (busy_i) begin
            r_cnt    <= r_cnt + CntW'(1);
            r_prod   <= w_prod_nxt;
            if (last_o) begin
                r_result <= w_final;
            end
        end
    end

    assign result_o = r_result;

endmodule

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control decoder plus sequencer for the iterative MUL/DIV unit.
// Define ALU_CTRL_DIV_EN to decode and execute DIV/DIVU/REM/REMU.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic [3:0]      ALUCtrl_o,
    output logic            illegal_o,
    output logic            stall_o,
    output logic            mdu_done_o,
    output logic [XLEN-1:0] mdu_result_o
);

    logic [6:0] w_f7;
    logic [2:0] w_f3;
    logic [3:0] w_dec;
    state_e     r_state, w_state_nxt;
    logic       w_start, w_busy, w_last;

    always_comb begin
        w_f7  = funct_i[9:3];
        w_f3  = funct_i[2:0];
        w_dec = OpNone;
        case (ALUOp_i)
            AluOpIType: begin
                if (w_f3 == 3'b000) begin
                    w_dec = OpAdd;
                end else if (w_f3 == 3'b101 && w_f7 == F7Alt) begin
                    w_dec = OpSrai;
                end else if (w_f3 == 3'b101 && w_f7 == F7Base) begin
                    w_dec = OpSrl;
                end
            end
            AluOpBranch: w_dec = OpSub;
            AluOpRType: begin
                if (w_f7 == F7Base) begin
                    case (w_f3)
                        3'b000:  w_dec = OpAdd;
                        3'b001:  w_dec = OpSll;
                        3'b010:  w_dec = OpSlt;
                        3'b100:  w_dec = OpXor;
                        3'b101:  w_dec = OpSrl;
                        3'b110:  w_dec = OpOr;
                        3'b111:  w_dec = OpAnd;
                        default: w_dec = OpNone;
                    endcase
                end else if (w_f7 == F7Alt && w_f3 == 3'b000) begin
                    w_dec = OpSub;
                end else if (w_f7 == F7Mext) begin
                    case (w_f3)
                        3'b000:  w_dec = OpMul;
                        3'b001:  w_dec = OpMulh;
`ifdef ALU_CTRL_DIV_EN
                        3'b100:  w_dec = OpDiv;
                        3'b101:  w_dec = OpDivu;
                        3'b110:  w_dec = OpRem;
                        3'b111:  w_dec = OpRemu;
`endif
                        default: w_dec = OpNone;
                    endcase
                end
            end
            default: w_dec = OpNone;
        endcase
    end

    // Every legal code is non-zero, so a zero decode on a live slot is illegal.
    assign ALUCtrl_o = valid_i ? w_dec : OpNone;
    assign illegal_o = valid_i && (w_dec == OpNone);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DONE never starts: the completed instruction is still presented that cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_busy      = 1'b0;
        stall_o     = 1'b0;
        mdu_done_o  = 1'b0;
        case (r_state)
            StIdle: begin
                if (valid_i && is_mdu_op(w_dec)) begin
                    stall_o     = 1'b1;
                    w_start     = 1'b1;
                    w_state_nxt = StBusy;
                end
            end
            StBusy: begin
                stall_o = 1'b1;
                w_busy  = 1'b1;
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                mdu_done_o  = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    mdu_iter #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_mdu (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (w_start),
        .busy_i   (w_busy),
        .op_i     (w_dec),
        .a_i      (rs1_data_i),
        .b_i      (rs2_data_i),
        .last_o   (w_last),
        .result_o (mdu_result_o)
    );

endmodule
